systolic_feeder: RTL and testbench

- Input-side stage sitting directly upstream of the systolic array. It runs alongside the array scheduler.
- Buffers one MATRIX_SIZE x MATRIX_SIZE activation matrix, written one row per beat over a valid/ready port.
- On start, streams the matrix into the array rows with diagonal skew. Row r is delayed by r wavefronts, and each wavefront is held for STEP_CYCLES cycles to match the PE multiply cadence.
- Raises a one-cycle done when the last wavefront has been presented.

---
 rtl/systolic_feeder.sv | 145 ++++++++++++++
 tb/tb_systolic_feeder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Activation feeder for the systolic array: buffers one NxN matrix row by row,
// then streams it out with a one-wavefront-per-row diagonal skew.

module systolic_feeder_lane #(
  parameter int N    = 2,
  parameter int D    = 32,
  parameter int ROW  = 0,
  parameter int WW   = 2
) (
  input  logic [WW-1:0]       wave,
  input  logic [N-1:0][D-1:0] row_data,
  output logic [D-1:0]        data,
  output logic                vld
);
  // Row ROW sees element k during wave ROW+k; outside that window the slot is empty.
  always_comb begin
    data = '0;
    vld  = 1'b0;
    for (int k = 0; k < N; k++)
      if (int'(wave) == ROW + k) begin
        data = row_data[k];
        vld  = 1'b1;
      end
  end
endmodule

module systolic_feeder #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int STEP_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            general_enable,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] wr_data,
  input  logic                            start,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] a_out,
  output logic [MATRIX_SIZE-1:0]          a_valid,
  output logic                            busy,
  output logic                            done
);
  localparam int N  = MATRIX_SIZE;
  localparam int D  = DATA_SIZE;
  localparam int WW = $clog2(2 * N);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int RW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, LOADED, STREAM, DONE} state_t;

  state_t                          state, state_n;
  logic [RW-1:0]                   row_cnt;
  logic [WW-1:0]                   wave, wave_sel;
  logic [SW-1:0]                   step;
  logic [N-1:0][N-1:0][D-1:0]      row_buf;
  logic [N-1:0][D-1:0]             nxt_out;
  logic [N-1:0]                    nxt_vld;
  logic                            wr_fire, go, step_end, last_wave;

  assign step_end  = (step == SW'(STEP_CYCLES - 1));
  assign last_wave = (wave == WW'(2 * N - 2));
  // Lanes look one wave ahead so the registered outputs line up with the counters.
  assign wave_sel  = (state == LOADED) ? '0 : wave + WW'(1);

  always_comb begin
    state_n = state;
    wr_fire = 1'b0;
    go      = 1'b0;
    case (state)
      IDLE: begin
        wr_fire = wr_valid & wr_ready;
        if (wr_fire && row_cnt == RW'(N - 1)) state_n = LOADED;
      end
      LOADED: if (start) begin
        go      = 1'b1;
        state_n = STREAM;
      end
      STREAM:  if (step_end && last_wave) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)               state <= IDLE;
    else if (general_enable) state <= state_n;

  generate
    for (genvar r = 0; r < N; r++) begin : g_lane
      systolic_feeder_lane #(.N(N), .D(D), .ROW(r), .WW(WW)) u_lane (
        .wave     (wave_sel),
        .row_data (row_buf[r]),
        .data     (nxt_out[r]),
        .vld      (nxt_vld[r])
      );
    end
  endgenerate

  // Matrix storage carries no reset; a fresh load always rewrites every row.
  always_ff @(posedge clk)
    if (general_enable && wr_fire)
      for (int r = 0; r < N; r++)
        if (row_cnt == RW'(r)) row_buf[r] <= wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt  <= '0;
      wave     <= '0;
      step     <= '0;
      a_out    <= '0;
      a_valid  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_ready <= 1'b0;
    end else if (general_enable) begin
      wr_ready <= (state_n == IDLE);
      done     <= (state == STREAM) && (state_n == DONE);
      if (wr_fire)             row_cnt <= row_cnt + RW'(1);
      else if (state == DONE)  row_cnt <= '0;
      if (go) begin
        wave    <= '0;
        step    <= '0;
        busy    <= 1'b1;
        a_out   <= nxt_out;
        a_valid <= nxt_vld;
      end else if (state == STREAM) begin
        if (step_end) begin
          step <= '0;
          if (last_wave) begin
            busy    <= 1'b0;
            a_out   <= '0;
            a_valid <= '0;
          end else begin
            wave    <= wave + WW'(1);
            a_out   <= nxt_out;
            a_valid <= nxt_vld;
          end
        end else begin
          step <= step + SW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: N=2/STEP=4 main instance plus an N=3/STEP=1 instance.

module tb_systolic_feeder;
  localparam int N = 2, D = 32, S = 4, N3 = 3;

  logic clk = 1'b0, reset = 1'b1, general_enable = 1'b1;
  logic wr_valid = 1'b0, start = 1'b0;
  logic [N*D-1:0] wr_data = '0;
  logic wr_ready, busy, done;
  logic [N*D-1:0] a_out;
  logic [N-1:0] a_valid;

  logic wr_valid3 = 1'b0, start3 = 1'b0;
  logic [N3*D-1:0] wr_data3 = '0;
  logic wr_ready3, busy3, done3;
  logic [N3*D-1:0] a_out3;
  logic [N3-1:0] a_valid3;

  int n_tests = 0, n_fail = 0;
  logic [N*D-1:0] exp_a [3];
  logic [N-1:0]   exp_v [3];
  logic [N*D-1:0] row0, row1;

  always #5 clk = ~clk;

  systolic_feeder #(.MATRIX_SIZE(N), .DATA_SIZE(D), .STEP_CYCLES(S)) u_dut (
    .clk(clk), .reset(reset), .general_enable(general_enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .start(start), .a_out(a_out), .a_valid(a_valid), .busy(busy), .done(done)
  );

  systolic_feeder #(.MATRIX_SIZE(N3), .DATA_SIZE(D), .STEP_CYCLES(1)) u_dut3 (
    .clk(clk), .reset(reset), .general_enable(general_enable),
    .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_data(wr_data3),
    .start(start3), .a_out(a_out3), .a_valid(a_valid3), .busy(busy3), .done(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load2();
    wr_valid = 1'b1;
    wr_data  = row0;
    tick();
    wr_data  = row1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream_check(input string tag, input bit stall);
    for (int w = 0; w < 3; w++)
      for (int s = 0; s < S; s++) begin
        chk(tag, 128'({busy, a_valid, a_out}), 128'({1'b1, exp_v[w], exp_a[w]}));
        if (stall && w == 1 && s == 1) begin
          general_enable = 1'b0;
          repeat (3) begin
            tick();
            chk({tag, "_hold"}, 128'({busy, a_valid, a_out}), 128'({1'b1, exp_v[w], exp_a[w]}));
          end
          general_enable = 1'b1;
        end
        tick();
      end
    chk({tag, "_done"}, 128'({done, busy, a_valid, wr_ready, a_out}), 128'({1'b1, 1'b0, 2'b00, 1'b0, 64'h0}));
    tick();
    chk({tag, "_idle"}, 128'({done, busy, wr_ready}), 128'(3'b001));
  endtask

  initial begin
    row0 = {32'h12, 32'h11};
    row1 = {32'h22, 32'h21};
    exp_v[0] = 2'b01; exp_a[0] = {32'h0,  32'h11};
    exp_v[1] = 2'b11; exp_a[1] = {32'h21, 32'h12};
    exp_v[2] = 2'b10; exp_a[2] = {32'h22, 32'h0};

    repeat (2) tick();
    chk("reset", 128'({wr_ready, busy, done, a_valid, a_out, wr_ready3, busy3, done3, a_valid3}), '0);
    reset = 1'b0;
    chk("rdy_low_after_release", 128'(wr_ready), 128'(1'b0));
    tick();
    chk("rdy_up", 128'({wr_ready, wr_ready3}), 128'(2'b11));

    // normal run, including a rejected third beat while LOADED
    load2();
    wr_valid = 1'b1;
    wr_data  = {32'hdeadbeef, 32'hdeadbeef};
    chk("loaded_rdy", 128'(wr_ready), 128'(1'b0));
    tick();
    wr_valid = 1'b0;
    chk("extra_beat_rdy", 128'({wr_ready, busy}), 128'(2'b00));
    pulse_start();
    stream_check("run1", 1'b0);

    // start with only row0 written must be ignored
    wr_valid = 1'b1;
    wr_data  = row0;
    tick();
    wr_valid = 1'b0;
    start = 1'b1;
    tick();
    tick();
    chk("early_start", 128'({busy, a_valid, wr_ready, done}), 128'(5'b00010));
    start = 1'b0;
    wr_valid = 1'b1;
    wr_data  = row1;
    tick();
    wr_valid = 1'b0;
    pulse_start();
    stream_check("early_run", 1'b0);

    // stall in the second wave stretches busy to 15 cycles
    load2();
    pulse_start();
    stream_check("stall", 1'b1);

    // done holds while stalled
    load2();
    pulse_start();
    repeat (3 * S) tick();
    general_enable = 1'b0;
    tick();
    tick();
    chk("done_hold", 128'({done, busy}), 128'(2'b10));
    general_enable = 1'b1;
    tick();
    chk("done_clear", 128'({done, wr_ready}), 128'(2'b01));

    // asynchronous reset in wave 1
    load2();
    pulse_start();
    repeat (5) tick();
    chk("pre_rst", 128'({busy, a_valid}), 128'(3'b111));
    reset = 1'b1;
    #1;
    chk("rst_mid", 128'({busy, a_valid, wr_ready, done, a_out}), '0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_rdy", 128'(wr_ready), 128'(1'b1));
    load2();
    pulse_start();
    stream_check("after_rst", 1'b0);

    // N=3, STEP_CYCLES=1: element (r,k) = (r+1)*16 + (k+1)
    wr_valid3 = 1'b1;
    for (int r = 0; r < N3; r++) begin
      for (int k = 0; k < N3; k++) wr_data3[k*D +: D] = 32'((r + 1) * 16 + k + 1);
      tick();
    end
    wr_valid3 = 1'b0;
    chk("n3_loaded", 128'(wr_ready3), 128'(1'b0));
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int w = 0; w < 2 * N3 - 1; w++) begin
      logic [N3*D-1:0] ea;
      logic [N3-1:0]   ev;
      ea = '0;
      ev = '0;
      for (int r = 0; r < N3; r++)
        if (w - r >= 0 && w - r < N3) begin
          ea[r*D +: D] = 32'((r + 1) * 16 + (w - r) + 1);
          ev[r] = 1'b1;
        end
      chk($sformatf("n3_wave%0d", w), 128'({busy3, a_valid3, a_out3}), 128'({1'b1, ev, ea}));
      tick();
    end
    chk("n3_done", 128'({done3, busy3, a_valid3}), 128'(5'b10000));
    tick();
    chk("n3_idle", 128'({done3, wr_ready3}), 128'(2'b01));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
